// File: rtl/audio_codec_config.sv
// Audio codec I2C configuration sequencer: writes the power-up register table,
// then services headphone-volume updates over a push-pull SCL / open-drain SDA bus.
//
// state | meaning
// IDLE  | bus released; accepts start or pending volume
// WAIT  | power-up delay after reset
// LOAD  | latch the next frame into the shift register
// START | START condition (2 quarters)
// BIT   | one data bit cell (4 quarters), MSB first
// ACK   | acknowledge cell, slave response sampled at end of Q1
// STOP  | STOP condition (3 quarters)
// GAP   | inter-frame idle (4 quarters), then retry/advance decision
module audio_codec_config #(
  parameter int unsigned QTR_DIV   = 125,
  parameter int unsigned PWR_WAIT  = 1000,
  parameter int unsigned MAX_RETRY = 3,
  parameter logic [6:0]  DEV_ADDR  = 7'h1A
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  output logic       i2c_SCLK,
  inout  wire        i2c_SDAT,
  input  logic       start,
  input  logic       vol_load,
  input  logic [6:0] vol,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int unsigned TMAX = (PWR_WAIT > QTR_DIV) ? PWR_WAIT : QTR_DIV;
  localparam int TW = $clog2(TMAX + 1);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TW-1:0] QTR_LD    = TW'(QTR_DIV - 1);
  localparam logic [TW-1:0] WAIT_LD   = TW'(PWR_WAIT - 1);
  localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);
  localparam logic [3:0]    LAST_IDX  = 4'd10;

  typedef enum logic [2:0] {IDLE, WAIT, LOAD, START, BIT, ACK, STOP, GAP} state_t;

  state_t state, state_nxt;
  logic [TW-1:0] tmr;
  logic [1:0]    qidx;
  logic          tick;
  logic          boot;
  logic [3:0]    idx;
  logic [RW-1:0] retry;
  logic          pending, vol_new, vol_frame;
  logic [6:0]    vol_q;
  logic          nack;
  logic [23:0]   sreg;
  logic [2:0]    bit_cnt;
  logic [1:0]    byte_cnt;
  logic [1:0]    sda_sync;
  logic          scl_q, sda_low_q, scl_c, sda_low_c;
  logic          frame_end, advance, last_frame;

  // {reg[6:0], data[8:0]}
  function automatic logic [15:0] tbl_entry(input logic [3:0] i);
    case (i)
      4'd0:    tbl_entry = {7'd15, 9'h000};
      4'd1:    tbl_entry = {7'd0,  9'h017};
      4'd2:    tbl_entry = {7'd1,  9'h017};
      4'd3:    tbl_entry = {7'd2,  9'h079};
      4'd4:    tbl_entry = {7'd3,  9'h079};
      4'd5:    tbl_entry = {7'd4,  9'h012};
      4'd6:    tbl_entry = {7'd5,  9'h000};
      4'd7:    tbl_entry = {7'd6,  9'h000};
      4'd8:    tbl_entry = {7'd7,  9'h042};
      4'd9:    tbl_entry = {7'd8,  9'h000};
      default: tbl_entry = {7'd9,  9'h001};
    endcase
  endfunction

  assign tick       = (tmr == '0);
  assign frame_end  = (state == GAP) && tick && (qidx == 2'd3);
  assign advance    = !nack || (retry == RETRY_LIM);
  assign last_frame = advance && (vol_frame || (idx == LAST_IDX));

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (boot) state_nxt = WAIT;
             else if (start || pending) state_nxt = LOAD;
      WAIT:  if (tick) state_nxt = LOAD;
      LOAD:  state_nxt = START;
      START: if (tick && qidx == 2'd1) state_nxt = BIT;
      BIT:   if (tick && qidx == 2'd3 && bit_cnt == 3'd0) state_nxt = ACK;
      ACK:   if (tick && qidx == 2'd3) state_nxt = (nack || byte_cnt == 2'd2) ? STOP : BIT;
      STOP:  if (tick && qidx == 2'd2) state_nxt = GAP;
      GAP:   if (frame_end) state_nxt = last_frame ? IDLE : LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    scl_c     = 1'b1;
    sda_low_c = 1'b0;
    unique case (state)
      START: begin
        scl_c     = (qidx == 2'd0);
        sda_low_c = 1'b1;
      end
      BIT: begin
        scl_c     = (qidx == 2'd1) || (qidx == 2'd2);
        sda_low_c = !sreg[23];
      end
      ACK:   scl_c = (qidx == 2'd1) || (qidx == 2'd2);
      STOP: begin
        scl_c     = (qidx != 2'd0);
        sda_low_c = (qidx != 2'd2);
      end
      default: ;
    endcase
  end

  // Quarter timer restarts on every state entry; WAIT reuses it for the power-up delay.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      tmr  <= QTR_LD;
      qidx <= 2'd0;
    end else if (state_nxt != state) begin
      tmr  <= (state_nxt == WAIT) ? WAIT_LD : QTR_LD;
      qidx <= 2'd0;
    end else if (tick) begin
      tmr  <= QTR_LD;
      qidx <= qidx + 2'd1;
    end else begin
      tmr  <= tmr - TW'(1);
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state     <= IDLE;
      boot      <= 1'b1;
      idx       <= 4'd0;
      retry     <= '0;
      error     <= 1'b0;
      pending   <= 1'b0;
      vol_new   <= 1'b0;
      vol_q     <= 7'd0;
      vol_frame <= 1'b0;
      nack      <= 1'b0;
      sreg      <= 24'd0;
      bit_cnt   <= 3'd0;
      byte_cnt  <= 2'd0;
      done      <= 1'b0;
      sda_sync  <= 2'b11;
      scl_q     <= 1'b1;
      sda_low_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      boot      <= 1'b0;
      done      <= 1'b0;
      sda_sync  <= {sda_sync[0], i2c_SDAT};
      scl_q     <= scl_c;
      sda_low_q <= sda_low_c;

      // vol_new marks a value that the frame in flight has not captured yet
      if (vol_load) begin
        vol_q   <= vol;
        vol_new <= 1'b1;
        pending <= 1'b1;
      end else if (state == LOAD && vol_frame) begin
        vol_new <= 1'b0;
      end

      if (state == IDLE && !boot) begin
        if (start) begin
          idx       <= 4'd0;
          error     <= 1'b0;
          retry     <= '0;
          vol_frame <= 1'b0;
        end else if (pending) begin
          vol_frame <= 1'b1;
        end
      end

      if (state == LOAD) begin
        sreg     <= {DEV_ADDR, 1'b0, vol_frame ? {7'd2, 2'b10, vol_q} : tbl_entry(idx)};
        bit_cnt  <= 3'd7;
        byte_cnt <= 2'd0;
        nack     <= 1'b0;
      end

      if (state == BIT && tick && qidx == 2'd3) begin
        sreg    <= {sreg[22:0], 1'b0};
        bit_cnt <= bit_cnt - 3'd1;
      end

      if (state == ACK && tick) begin
        if (qidx == 2'd1 && sda_sync[1]) nack <= 1'b1;
        if (qidx == 2'd3) byte_cnt <= byte_cnt + 2'd1;
      end

      if (frame_end) begin
        if (advance) begin
          retry <= '0;
          if (nack) error <= 1'b1;
          if (vol_frame) begin
            if (!vol_new && !vol_load) pending <= 1'b0;
          end else if (idx == LAST_IDX) begin
            idx  <= 4'd0;
            done <= 1'b1;
          end else begin
            idx <= idx + 4'd1;
          end
        end else begin
          retry <= retry + RW'(1);
        end
      end
    end
  end

  assign i2c_SCLK = scl_q;
  assign i2c_SDAT = sda_low_q ? 1'b0 : 1'bz;
  assign busy     = (state != IDLE) || pending;

endmodule

// File: tb/tb_audio_codec_config.sv
// Bench for audio_codec_config: an I2C slave model decodes frames on the bus and a
// monitor compares them against a queue of expected frames pushed by the stimulus.
module tb_audio_codec_config;

  localparam int QTR = 4;
  localparam int PWR = 10;

  logic       clk_clk = 1'b0;
  logic       reset_reset = 1'b1;
  logic       start = 1'b0;
  logic       vol_load = 1'b0;
  logic [6:0] vol = 7'd0;
  logic       i2c_SCLK, busy, done, error;
  wire        i2c_SDAT;
  logic       slv_drv = 1'b0;

  assign i2c_SDAT = slv_drv ? 1'b0 : 1'bz;
  pullup (i2c_SDAT);

  audio_codec_config #(
    .QTR_DIV(QTR), .PWR_WAIT(PWR), .MAX_RETRY(3), .DEV_ADDR(7'h1A)
  ) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset), .i2c_SCLK(i2c_SCLK), .i2c_SDAT(i2c_SDAT),
    .start(start), .vol_load(vol_load), .vol(vol), .busy(busy), .done(done), .error(error)
  );

  always #5 clk_clk = ~clk_clk;

  typedef struct {
    logic [23:0] d;
    int          nb;
    bit          nk;
  } frame_t;

  frame_t exp_q[$];
  int total = 0;
  int bad = 0;
  int done_seen = 0;

  // {byte1, byte2} of each table entry, hand-encoded
  logic [15:0] tbl [11] = '{16'h1E00, 16'h0017, 16'h0217, 16'h0479, 16'h0679, 16'h0812,
                            16'h0A00, 16'h0C00, 16'h0E42, 16'h1000, 16'h1201};

  bit          in_frame = 1'b0;
  int          bitpos = 0;
  int          nbytes = 0;
  logic [7:0]  sh = 8'd0;
  logic [23:0] obs = 24'd0;
  bit          fnack = 1'b0;
  bit          do_ack = 1'b1;
  logic        p_scl = 1'b1;
  logic        p_sda = 1'b1;
  logic [6:0]  nack_reg = 7'd0;
  int          nack_left = 0;

  task automatic chk(input string nm, input bit act, input bit exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b required %0b", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic push_ok(input logic [15:0] e);
    frame_t f;
    f.d = {8'h34, e};
    f.nb = 3;
    f.nk = 1'b0;
    exp_q.push_back(f);
  endtask

  task automatic push_nk(input logic [15:0] e);
    frame_t f;
    f.d = {8'h00, 8'h34, e[15:8]};
    f.nb = 2;
    f.nk = 1'b1;
    exp_q.push_back(f);
  endtask

  // nk_n NACKed attempts of entry nk_i; four attempts means the entry is skipped
  task automatic push_table(input int nk_i, input int nk_n);
    for (int i = 0; i < 11; i++) begin
      if (i == nk_i) for (int k = 0; k < nk_n; k++) push_nk(tbl[i]);
      if (i != nk_i || nk_n <= 3) push_ok(tbl[i]);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk_clk);
    start = 1'b1;
    @(negedge clk_clk);
    start = 1'b0;
  endtask

  task automatic load_vol(input logic [6:0] v);
    @(negedge clk_clk);
    vol = v;
    vol_load = 1'b1;
    @(negedge clk_clk);
    vol_load = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int maxc, output bit busy_at);
    bit seen;
    seen = 1'b0;
    busy_at = 1'b1;
    for (int n = 0; n < maxc && !seen; n++) begin
      @(negedge clk_clk);
      if (done) begin
        seen = 1'b1;
        busy_at = busy;
      end
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s_timeout: done not seen within %0d cycles", nm, maxc);
    end
  endtask

  // Slave model, frame decoder and scoreboard monitor
  initial begin
    logic scl, sda;
    frame_t e;
    forever begin
      @(negedge clk_clk);
      if (done) done_seen++;
      scl = i2c_SCLK;
      sda = i2c_SDAT;
      if (reset_reset) begin
        in_frame = 1'b0;
        slv_drv = 1'b0;
        bitpos = 0;
      end else if (scl && p_scl && p_sda && !sda) begin
        in_frame = 1'b1;
        bitpos = 0;
        nbytes = 0;
        obs = 24'd0;
        fnack = 1'b0;
      end else if (scl && p_scl && !p_sda && sda) begin
        if (in_frame) begin
          in_frame = 1'b0;
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL frame_extra: got %h nbytes=%0d nack=%0b required no frame", obs, nbytes, fnack);
          end else begin
            e = exp_q.pop_front();
            if (obs !== e.d || nbytes != e.nb || fnack != e.nk) begin
              bad++;
              $display("FAIL frame: got %h nbytes=%0d nack=%0b required %h nbytes=%0d nack=%0b",
                       obs, nbytes, fnack, e.d, e.nb, e.nk);
            end
          end
        end
      end else if (in_frame && scl && !p_scl) begin
        if (bitpos < 8) begin
          sh = {sh[6:0], sda};
          bitpos++;
          if (bitpos == 8) begin
            obs = {obs[15:0], sh};
            nbytes++;
            do_ack = 1'b1;
            if (nbytes == 2 && sh[7:1] == nack_reg && nack_left != 0) begin
              do_ack = 1'b0;
              if (nack_left > 0) nack_left--;
            end
          end
        end else if (bitpos == 8) begin
          if (sda) fnack = 1'b1;
          bitpos = 9;
        end
      end else if (in_frame && !scl && p_scl) begin
        if (bitpos == 8) slv_drv = do_ack;
        else if (bitpos == 9) begin
          slv_drv = 1'b0;
          bitpos = 0;
        end
      end
      p_scl = scl;
      p_sda = sda;
    end
  end

  initial begin
    bit busy_at, found;
    int d0, lat;

    repeat (3) @(negedge clk_clk);
    chk("rst_scl", i2c_SCLK, 1'b1);
    chk("rst_sda", i2c_SDAT, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);

    // power-up table run
    push_table(-1, 0);
    d0 = done_seen;
    reset_reset = 1'b0;
    wait_done("boot", 8000, busy_at);
    chk("boot_busy_at_done", busy_at, 1'b0);
    chk("boot_error", error, 1'b0);
    repeat (20) @(negedge clk_clk);
    chki("boot_done_count", done_seen - d0, 1);
    chki("boot_queue_left", exp_q.size(), 0);

    // R4 NACKed on every attempt
    nack_reg = 7'd4;
    nack_left = -1;
    push_table(5, 4);
    d0 = done_seen;
    pulse_start();
    wait_done("r4nack", 12000, busy_at);
    chk("r4nack_error", error, 1'b1);
    repeat (20) @(negedge clk_clk);
    chki("r4nack_done_count", done_seen - d0, 1);
    chki("r4nack_queue_left", exp_q.size(), 0);

    // restart from IDLE after the error run; R7 NACKed once; start while busy ignored
    nack_reg = 7'd7;
    nack_left = 1;
    push_table(8, 1);
    d0 = done_seen;
    @(negedge clk_clk);
    start = 1'b1;
    @(negedge clk_clk);
    start = 1'b0;
    chk("restart_error_cleared", error, 1'b0);
    lat = 0;
    while (!in_frame && lat < 40) begin
      @(negedge clk_clk);
      lat++;
    end
    chk("restart_no_pwr_wait", lat < 8, 1'b1);
    repeat (1500) @(negedge clk_clk);
    pulse_start();
    wait_done("r7nack", 12000, busy_at);
    chk("r7nack_error", error, 1'b0);
    repeat (20) @(negedge clk_clk);
    chki("r7nack_done_count", done_seen - d0, 1);
    chki("r7nack_queue_left", exp_q.size(), 0);

    // two volume loads during a table run; only the last value is written, after the table
    push_table(-1, 0);
    push_ok(16'h0530);
    d0 = done_seen;
    pulse_start();
    repeat (1000) @(negedge clk_clk);
    load_vol(7'h55);
    repeat (1000) @(negedge clk_clk);
    load_vol(7'h30);
    wait_done("vol", 8000, busy_at);
    chk("vol_busy_at_done", busy_at, 1'b1);
    found = 1'b0;
    for (int n = 0; n < 1500 && !found; n++) begin
      @(negedge clk_clk);
      if (!busy) found = 1'b1;
    end
    chk("vol_busy_falls", found, 1'b1);
    repeat (20) @(negedge clk_clk);
    chki("vol_done_count", done_seen - d0, 1);
    chki("vol_queue_left", exp_q.size(), 0);
    chk("vol_error", error, 1'b0);

    // reset in the middle of byte1 of the first frame
    push_table(-1, 0);
    pulse_start();
    found = 1'b0;
    for (int n = 0; n < 2000 && !found; n++) begin
      @(negedge clk_clk);
      if (in_frame && nbytes == 1 && bitpos == 3 && !i2c_SCLK) found = 1'b1;
    end
    chk("midreset_reached_byte1", found, 1'b1);
    reset_reset = 1'b1;
    #1;
    chk("midreset_scl", i2c_SCLK, 1'b1);
    chk("midreset_sda", i2c_SDAT, 1'b1);
    chk("midreset_busy", busy, 1'b0);
    exp_q.delete();
    push_table(-1, 0);
    d0 = done_seen;
    repeat (3) @(negedge clk_clk);
    reset_reset = 1'b0;
    wait_done("midreset", 8000, busy_at);
    chk("midreset_error", error, 1'b0);
    repeat (20) @(negedge clk_clk);
    chki("midreset_done_count", done_seen - d0, 1);
    chki("midreset_queue_left", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
